sync_fifo_flex: RTL and testbench

Parametrised successor to the team's basic synchronous FIFO, for single-clock buffering between datapath stages.

---
 rtl/sync_fifo_flex.sv | 169 ++++++++++++++++
 tb/tb_sync_fifo_flex.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: parametrised single-clock FIFO for buffering between datapath
// stages. Provides occupancy count, programmable almost-full/almost-empty
// thresholds, simultaneous read+write when full, and either a registered
// (FWFT=0) or first-word-fall-through (FWFT=1) read port.
//
// Optional build macro SYNC_FIFO_FLEX_ERR_FLAGS_EN: when defined, overflow and
// underflow become sticky error flags (cleared only by rst); when undefined the
// ports remain but are tied low.
module sync_fifo_flex #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0,
    localparam int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    // Thresholds and constants resized to the counter width so every compare
    // and increment is width-matched.
    localparam logic [PTR_WIDTH:0] PTR_ONE   = {{PTR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH:0] DEPTH_CNT = DEPTH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AF_CNT    = AF_LEVEL[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AE_CNT    = AE_LEVEL[PTR_WIDTH:0];

    // Storage is deliberately not reset; stale words become unreachable once
    // the pointers are cleared.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry an extra wrap bit and roll over modulo 2*DEPTH.
    logic [PTR_WIDTH:0] w_ptr_q, w_ptr_d;
    logic [PTR_WIDTH:0] r_ptr_q, r_ptr_d;
    logic [PTR_WIDTH:0] count_q, count_d;

    logic rd_ok;
    logic wr_ok;

    logic [PTR_WIDTH-1:0] w_addr;
    logic [PTR_WIDTH-1:0] r_addr;

    assign w_addr = w_ptr_q[PTR_WIDTH-1:0];
    assign r_addr = r_ptr_q[PTR_WIDTH-1:0];

    // Status flags come straight from the registered occupancy.
    always_comb begin
        full         = (count_q == DEPTH_CNT);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AF_CNT);
        almost_empty = (count_q <= AE_CNT);
        count        = count_q;
    end

    // Acceptance: a read needs data; a write needs room, or a read freeing a
    // slot in the same cycle (the read still returns the old head word).
    always_comb begin
        rd_ok = r_en & ~empty;
        wr_ok = w_en & (~full | rd_ok);
    end

    // Next-state for pointers and occupancy; rejected operations change nothing.
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        if (wr_ok) begin
            w_ptr_d = w_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            r_ptr_d = r_ptr_q + PTR_ONE;
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
        end
    end

    // Storage write; gated by reset so a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[w_addr] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is always presented; meaningless while empty.
            always_comb begin
                data_out = mem[r_addr];
            end
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q, dout_d;

            // Registered read: capture the head on an accepted read, hold otherwise.
            always_comb begin
                dout_d = dout_q;
                if (rd_ok) begin
                    dout_d = mem[r_addr];
                end
            end

            // Read data register, cleared by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error accumulation: any rejected write or read on empty latches.
    always_comb begin
        overflow_d  = overflow_q | (w_en & ~wr_ok);
        underflow_d = underflow_q | (r_en & empty);
    end

    // Error flag registers; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex: one registered-read instance and one
// FWFT instance share stimulus; a scoreboard queue tracks expected data.
module tb_sync_fifo_flex;

`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] data_out, f_data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] count, f_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];
    int         mc = 0;
    logic [7:0] exp_d = '0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_flex #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(f_data_out), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    // One clock of stimulus; updates the reference model and scoreboard.
    task automatic cyc(input bit w, input bit r, input logic [7:0] d);
        bit rd, wr;
        w_en = w; r_en = r; data_in = d;
        if (rst) begin
            sb.delete();
            mc = 0;
        end else begin
            rd = r && (mc != 0);
            wr = w && ((mc != 8) || rd);
            if (rd) exp_d = sb.pop_front();
            if (wr) sb.push_back(d);
            mc = mc + int'(wr) - int'(rd);
        end
        @(posedge clk); #1;
        w_en = 1'b0; r_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);
        rst = 1'b0;
        exp_d = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        cyc(0, 0, 8'h00);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
        total++; if (full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b/%b exp=0/0", full, almost_full); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", data_out); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
        total++; if (f_empty !== 1'b1 || f_count !== 4'd0) begin bad++; $display("FAIL reset_fwft got=%b/%0d exp=1/0", f_empty, f_count); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 8'(i));
            total++; if (count !== 4'(mc)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", count, mc); end
            total++; if (almost_full !== (mc >= 6)) begin bad++; $display("FAIL fill_af cnt=%0d got=%b", mc, almost_full); end
            total++; if (almost_empty !== (mc <= 2)) begin bad++; $display("FAIL fill_ae cnt=%0d got=%b", mc, almost_empty); end
            total++; if (full !== (mc == 8)) begin bad++; $display("FAIL fill_full cnt=%0d got=%b", mc, full); end
        end
        for (int i = 0; i < 8; i++) begin
            total++; if (f_data_out !== sb[0]) begin bad++; $display("FAIL fwft_head got=%h exp=%h", f_data_out, sb[0]); end
            cyc(0, 1, 8'h00);
            total++; if (data_out !== exp_d) begin bad++; $display("FAIL drain_data got=%h exp=%h", data_out, exp_d); end
            total++; if (count !== 4'(mc)) begin bad++; $display("FAIL drain_count got=%0d exp=%0d", count, mc); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i));
        cyc(1, 1, 8'hAA);
        total++; if (data_out !== 8'h01 || data_out !== exp_d) begin bad++; $display("FAIL fullrw_data got=%h exp=01", data_out); end
        total++; if (count !== 4'd8 || full !== 1'b1) begin bad++; $display("FAIL fullrw_count got=%0d full=%b exp=8/1", count, full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullrw_ovf got=%b exp=0", overflow); end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 8'h00);
            total++; if (data_out !== exp_d) begin bad++; $display("FAIL fullrw_drain got=%h exp=%h", data_out, exp_d); end
        end
        total++; if (data_out !== 8'hAA) begin bad++; $display("FAIL fullrw_last got=%h exp=aa", data_out); end
    endtask

    task automatic test_fwft();
        do_reset();
        cyc(1, 0, 8'h5C);
        total++; if (f_empty !== 1'b0) begin bad++; $display("FAIL fwft_empty got=%b exp=0", f_empty); end
        total++; if (f_data_out !== 8'h5C) begin bad++; $display("FAIL fwft_show got=%h exp=5c", f_data_out); end
        cyc(0, 1, 8'h00);
        total++; if (f_empty !== 1'b1 || f_count !== 4'd0) begin bad++; $display("FAIL fwft_pop got=%b/%0d exp=1/0", f_empty, f_count); end
    endtask

    task automatic test_err_flags();
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(8'h10 + i));
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL err_ovf_early got=%b exp=0", overflow); end
        cyc(1, 0, 8'hFF);
        total++; if (overflow !== ERR) begin bad++; $display("FAIL err_ovf got=%b exp=%b", overflow, ERR); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL err_ovf_count got=%0d exp=8", count); end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 8'h00);
            total++; if (data_out !== exp_d) begin bad++; $display("FAIL err_drain got=%h exp=%h", data_out, exp_d); end
        end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL err_unf_early got=%b exp=0", underflow); end
        cyc(0, 1, 8'h00);
        total++; if (underflow !== ERR) begin bad++; $display("FAIL err_unf got=%b exp=%b", underflow, ERR); end
        total++; if (data_out !== 8'h18 || count !== 4'd0) begin bad++; $display("FAIL err_unf_hold got=%h/%0d exp=18/0", data_out, count); end
        cyc(0, 0, 8'h00);
        cyc(1, 0, 8'h33);
        cyc(0, 1, 8'h00);
        total++; if (overflow !== ERR || underflow !== ERR) begin bad++; $display("FAIL err_sticky got=%b%b exp=%b%b", overflow, underflow, ERR, ERR); end
        total++; if (f_overflow !== ERR || f_underflow !== ERR) begin bad++; $display("FAIL err_sticky_f got=%b%b exp=%b%b", f_overflow, f_underflow, ERR, ERR); end
        do_reset();
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL err_clear got=%b%b exp=00", overflow, underflow); end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        for (int i = 1; i <= 5; i++) cyc(1, 0, 8'(8'h40 + i));
        cyc(0, 1, 8'h00);
        total++; if (data_out !== 8'h41) begin bad++; $display("FAIL mid_pre got=%h exp=41", data_out); end
        rst = 1'b1;
        cyc(1, 1, 8'h77);
        rst = 1'b0;
        total++; if (count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL mid_rst got=%0d/%b exp=0/1", count, empty); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_dout got=%h exp=00", data_out); end
        total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL mid_fempty got=%b exp=1", f_empty); end
        cyc(0, 1, 8'h00);
        total++; if (data_out !== 8'h00 || count !== 4'd0) begin bad++; $display("FAIL mid_rdrej got=%h/%0d exp=00/0", data_out, count); end
        total++; if (underflow !== ERR) begin bad++; $display("FAIL mid_unf got=%b exp=%b", underflow, ERR); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_fwft();
        test_err_flags();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
